ad9910_spi_shifter: RTL and testbench

Serial shift engine that drives the AD9910 serial port (CSB, SCLK, SDIO) and captures read-back data from SDO. It sits directly downstream of the half-period tick divider. It asserts `count_enable` to run the divider and advances one SCLK phase on each `count_end` tick. Upstream register-access logic hands it one left-aligned-by-length word per transaction.

---
 rtl/ad9910_spi_pkg.sv | 21 ++
 rtl/ad9910_spi_shifter.sv | 153 +++++++++++++++
 tb/tb_ad9910_spi_shifter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ad9910_spi_pkg.sv
// Shared types and constants for the AD9910 serial-port shift engine.
package ad9910_spi_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int LEN_WIDTH  = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_HOLD,
        S_GAP
    } spi_state_t;

    // A length field of zero encodes a full-width transfer.
    function automatic logic [LEN_WIDTH-1:0] len_to_bits(input logic [LEN_WIDTH-1:0] len);
        return (len == '0) ? LEN_WIDTH'(DATA_WIDTH) : len;
    endfunction

endpackage

// File: rtl/ad9910_spi_shifter.sv
// Drives CSB/SCLK/SDIO for one AD9910 transaction per start and captures SDO.
// Advances one SCLK phase per divider tick; every pin is driven from a flop.
module ad9910_spi_shifter #(
    parameter int DATA_WIDTH = ad9910_spi_pkg::DATA_WIDTH,
    parameter int LEN_WIDTH  = ad9910_spi_pkg::LEN_WIDTH
) (
    input  logic                  CLK100MHZ,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic [LEN_WIDTH-1:0]  tx_len,
    input  logic                  count_end,
    output logic                  count_enable,
    input  logic                  sdo_in,
    output logic                  csb,
    output logic                  sclk,
    output logic                  sdio,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rx_data
);
    import ad9910_spi_pkg::*;

    spi_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  csb_q, csb_d;
    logic                  sclk_q, sclk_d;
    logic                  sdio_q, sdio_d;
    logic                  ce_q, ce_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [LEN_WIDTH-1:0]  len_bits;
    logic [DATA_WIDTH-1:0] tx_load;

    // Left-align the payload so the first bit to send always sits in the MSB.
    assign len_bits = len_to_bits(tx_len);
    assign tx_load  = tx_data << (LEN_WIDTH'(DATA_WIDTH) - len_bits);

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rx_data_d = rx_data_q;
        cnt_d     = cnt_q;
        csb_d     = csb_q;
        sclk_d    = sclk_q;
        sdio_d    = sdio_q;
        ce_d      = ce_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SETUP;
                    tx_d    = tx_load;
                    rx_d    = '0;
                    cnt_d   = len_bits;
                    csb_d   = 1'b0;
                    sdio_d  = tx_load[DATA_WIDTH-1];
                    ce_d    = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_SETUP, S_LOW: begin
                if (count_end) begin
                    state_d = S_HIGH;
                    sclk_d  = 1'b1;
                    rx_d    = {rx_q[DATA_WIDTH-2:0], sdo_in};
                end
            end
            S_HIGH: begin
                if (count_end) begin
                    sclk_d = 1'b0;
                    // On the last bit SDIO is held through HOLD instead of shifting.
                    if (cnt_q > LEN_WIDTH'(1)) begin
                        state_d = S_LOW;
                        tx_d    = tx_q << 1;
                        sdio_d  = tx_q[DATA_WIDTH-2];
                        cnt_d   = cnt_q - LEN_WIDTH'(1);
                    end else begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (count_end) begin
                    state_d   = S_GAP;
                    csb_d     = 1'b1;
                    sdio_d    = 1'b0;
                    done_d    = 1'b1;
                    rx_data_d = rx_q;
                end
            end
            S_GAP: begin
                if (count_end) begin
                    state_d = S_IDLE;
                    ce_d    = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                csb_d   = 1'b1;
                sclk_d  = 1'b0;
                sdio_d  = 1'b0;
                ce_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_data_q <= '0;
            cnt_q     <= '0;
            csb_q     <= 1'b1;
            sclk_q    <= 1'b0;
            sdio_q    <= 1'b0;
            ce_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rx_data_q <= rx_data_d;
            cnt_q     <= cnt_d;
            csb_q     <= csb_d;
            sclk_q    <= sclk_d;
            sdio_q    <= sdio_d;
            ce_q      <= ce_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign count_enable = ce_q;
    assign csb          = csb_q;
    assign sclk         = sclk_q;
    assign sdio         = sdio_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign rx_data      = rx_data_q;

endmodule

// File: tb/tb_ad9910_spi_shifter.sv
// Directed bench for ad9910_spi_shifter with a half-period divider and SDO model.
module tb_ad9910_spi_shifter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [63:0] tx_data;
    logic [6:0]  tx_len;
    logic        count_end;
    logic        count_enable;
    logic        sdo_in;
    logic        csb;
    logic        sclk;
    logic        sdio;
    logic        busy;
    logic        done;
    logic [63:0] rx_data;

    int checks = 0;
    int errors = 0;

    ad9910_spi_shifter dut (
        .CLK100MHZ   (clk),
        .reset_n     (reset_n),
        .start       (start),
        .tx_data     (tx_data),
        .tx_len      (tx_len),
        .count_end   (count_end),
        .count_enable(count_enable),
        .sdo_in      (sdo_in),
        .csb         (csb),
        .sclk        (sclk),
        .sdio        (sdio),
        .busy        (busy),
        .done        (done),
        .rx_data     (rx_data)
    );

    always #5 clk = ~clk;

    // Half-period divider: reloads while disabled, ticks every H cycles.
    int H = 1;
    int div_cnt = 0;
    always @(posedge clk) begin
        if (!count_enable || div_cnt == 0) div_cnt <= H - 1;
        else                               div_cnt <= div_cnt - 1;
    end
    assign count_end = (div_cnt == 0);

    // SDO model: first bit presented while CSB is high, next bit after each SCLK fall.
    logic [63:0] sdo_word;
    int          sdo_len;
    int          sdo_idx = 0;
    logic        sclk_prev = 1'b0;
    always @(negedge clk) begin
        if (csb === 1'b1)                                sdo_idx = sdo_len - 1;
        else if (sclk_prev && !sclk && sdo_idx > 0)      sdo_idx = sdo_idx - 1;
        sclk_prev = sclk;
        sdo_in    = sdo_word[sdo_idx[5:0]];
    end

    // Activity monitor sampled on the inactive edge.
    int cyc = 0, busy_cnt = 0, done_cnt = 0, done_last = 0, done_prev = 0;
    int hi_run = 0, last_hi_run = 0;
    always @(negedge clk) begin
        cyc++;
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) begin
            done_cnt++;
            done_prev = done_last;
            done_last = cyc;
        end
        if (csb === 1'b1) hi_run++;
        else begin
            if (hi_run > 0) last_hi_run = hi_run;
            hi_run = 0;
        end
    end

    // Bits seen on SDIO at each SCLK rising edge.
    logic [63:0] cap = '0;
    int          pulses = 0;
    always @(posedge sclk) begin
        cap = {cap[62:0], sdio};
        pulses++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] d, input logic [6:0] l, output int t0);
        tick();
        tx_data = d;
        tx_len  = l;
        start   = 1'b1;
        t0      = cyc;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        int n0;
        n0 = done_cnt;
        for (int i = 0; i < max; i++) begin
            tick();
            if (done_cnt != n0) return;
        end
        checks++;
        errors++;
        $display("FAIL %s timeout waiting for done after %0d cycles", tag, max);
    endtask

    task automatic wait_idle(input string tag, input int max);
        for (int i = 0; i < max; i++) begin
            if (busy === 1'b0) return;
            tick();
        end
        checks++;
        errors++;
        $display("FAIL %s timeout waiting for idle after %0d cycles", tag, max);
    endtask

    int t0, b0, p0, d0;
    logic found;

    initial begin
        reset_n  = 1'b1;
        start    = 1'b0;
        tx_data  = '0;
        tx_len   = '0;
        sdo_word = '0;
        sdo_len  = 1;
        #2 reset_n = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_csb",  64'(csb), 64'd1);
        chk("rst_sclk", 64'(sclk), 64'd0);
        chk("rst_sdio", 64'(sdio), 64'd0);
        chk("rst_ce",   64'(count_enable), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rx",   rx_data, 64'd0);
        reset_n = 1'b1;
        repeat (2) tick();

        // Single 8-bit write, H=4
        H = 4;
        b0 = busy_cnt; p0 = pulses; d0 = done_cnt;
        send(64'hA5, 7'd8, t0);
        wait_done("wr8_done", 200);
        chk("wr8_done_lat", 64'(done_last - t0), 64'd69);
        chk("wr8_csb_at_done", 64'(csb), 64'd1);
        wait_idle("wr8_idle", 50);
        chk("wr8_busy_len", 64'(busy_cnt - b0), 64'd72);
        chk("wr8_pulses", 64'(pulses - p0), 64'd8);
        chk("wr8_bits", {56'd0, cap[7:0]}, 64'hA5);
        chk("wr8_ndone", 64'(done_cnt - d0), 64'd1);

        // Full width, H=1
        H = 1;
        tick();
        b0 = busy_cnt; p0 = pulses;
        send(64'h8000_0000_0000_0001, 7'd0, t0);
        wait_done("w64_done", 400);
        chk("w64_done_lat", 64'(done_last - t0), 64'd130);
        wait_idle("w64_idle", 20);
        chk("w64_busy_len", 64'(busy_cnt - b0), 64'd130);
        chk("w64_pulses", 64'(pulses - p0), 64'd64);
        chk("w64_bits", cap, 64'h8000_0000_0000_0001);

        // Read-back, N=32, H=2
        H = 2;
        sdo_word = 64'hDEAD_BEEF;
        sdo_len  = 32;
        tick();
        p0 = pulses;
        send(64'h1234_5678, 7'd32, t0);
        wait_done("rd32_done", 400);
        chk("rd32_done_lat", 64'(done_last - t0), 64'd131);
        chk("rd32_rx", rx_data, 64'h0000_0000_DEAD_BEEF);
        chk("rd32_bits", {32'd0, cap[31:0]}, 64'h1234_5678);
        wait_idle("rd32_idle", 20);
        repeat (5) tick();
        chk("rd32_rx_held", rx_data, 64'h0000_0000_DEAD_BEEF);
        sdo_word = '0;

        // Start while busy is ignored
        H = 4;
        tick();
        p0 = pulses; d0 = done_cnt;
        send(64'h3C, 7'd8, t0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (sclk === 1'b1) found = 1'b1;
        end
        chk("ign_reach_high", 64'(found), 64'd1);
        tx_data = 64'hFFFF;
        tx_len  = 7'd16;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        wait_done("ign_done", 200);
        chk("ign_done_lat", 64'(done_last - t0), 64'd69);
        wait_idle("ign_idle", 50);
        repeat (20) tick();
        chk("ign_pulses", 64'(pulses - p0), 64'd8);
        chk("ign_bits", {56'd0, cap[7:0]}, 64'h3C);
        chk("ign_ndone", 64'(done_cnt - d0), 64'd1);
        chk("ign_busy", 64'(busy), 64'd0);

        // Asynchronous reset mid-HIGH, N=24, H=4
        tick();
        p0 = pulses; d0 = done_cnt;
        send(64'hAB_CDEF, 7'd24, t0);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (sclk === 1'b1 && (pulses - p0) >= 5) found = 1'b1;
        end
        chk("mid_reach_high", 64'(found), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_csb",  64'(csb), 64'd1);
        chk("mid_sclk", 64'(sclk), 64'd0);
        chk("mid_sdio", 64'(sdio), 64'd0);
        chk("mid_ce",   64'(count_enable), 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_rx",   rx_data, 64'd0);
        repeat (3) tick();
        chk("mid_no_done", 64'(done_cnt - d0), 64'd0);
        reset_n = 1'b1;
        repeat (2) tick();

        // Normal transaction after reset, N=8, H=2
        H = 2;
        tick();
        p0 = pulses; d0 = done_cnt;
        send(64'h5A, 7'd8, t0);
        wait_done("post_done", 200);
        chk("post_done_lat", 64'(done_last - t0), 64'd35);
        wait_idle("post_idle", 20);
        chk("post_bits", {56'd0, cap[7:0]}, 64'h5A);
        chk("post_ndone", 64'(done_cnt - d0), 64'd1);

        // Back-to-back with start held high, N=8, H=3
        H = 3;
        repeat (3) tick();
        tx_data = 64'h96;
        tx_len  = 7'd8;
        start   = 1'b1;
        wait_done("b2b_done1", 200);
        wait_done("b2b_done2", 200);
        start   = 1'b0;
        chk("b2b_period", 64'(done_last - done_prev), 64'd55);
        chk("b2b_csb_gap", 64'(last_hi_run), 64'd4);
        chk("b2b_bits", {56'd0, cap[7:0]}, 64'h96);
        wait_idle("b2b_idle", 50);
        repeat (10) tick();
        chk("b2b_stopped", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
